// File: rtl/regression_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// regression_scheduler_pkg
// Shared definitions for the backward-induction regression scheduler and the
// 3x3 normal-equation solver it drives.
//   state_t        : scheduler FSM state encoding
//   DEFAULT_WIDTH  : default fixed-point width of one beta coefficient
//   idx_width()    : bit width of a step index (never less than 1)
// -----------------------------------------------------------------------------
package regression_scheduler_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regression_scheduler.sv
// -----------------------------------------------------------------------------
// regression_scheduler
// Sequences one regression solve per time step, from step NUM_STEPS-1 down to
// step 0: request matrices, start the solver, wait for its result, publish it.
//
// Optional feature: define REGRESSION_SCHED_TIMEOUT_EN to build the WAIT
// watchdog. Without it WAIT waits forever and err is constant 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   go           in   run request (accepted in IDLE or ERR)
//   abort        in   cancel the current run
//   busy         out  run in progress
//   done         out  one-cycle run-complete pulse
//   err          out  sticky solver-timeout flag
//   step_req     out  request matrix data for step_idx
//   step_idx     out  current time step
//   mat_valid    in   matrices for step_idx are stable
//   solver_start out  one-cycle solver start pulse
//   solver_done  in   solver completion
//   solver_beta  in   solver result, beta[0] in the LSBs
//   beta_valid   out  one-cycle result strobe
//   beta_step    out  step index belonging to beta_out
//   beta_out     out  latched coefficients
// -----------------------------------------------------------------------------
module regression_scheduler
  import regression_scheduler_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int NUM_STEPS = 16,
  parameter  int TIMEOUT   = 64,
  localparam int IDX_W     = idx_width(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               step_req,
  output logic [IDX_W-1:0]   step_idx,
  input  logic               mat_valid,
  output logic               solver_start,
  input  logic               solver_done,
  input  logic [3*WIDTH-1:0] solver_beta,
  output logic               beta_valid,
  output logic [IDX_W-1:0]   beta_step,
  output logic [3*WIDTH-1:0] beta_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_step_req;
  logic [IDX_W-1:0]     r_step_idx;
  logic                 r_solver_start;
  logic                 r_beta_valid;
  logic [IDX_W-1:0]     r_beta_step;
  logic [3*WIDTH-1:0]   r_beta_out;
  logic                 w_expire;

`ifdef REGRESSION_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  // Counter sits at 0 outside WAIT, so it is clear on every WAIT entry.
  // Expiry fires in the TIMEOUT-th WAIT cycle.
  assign w_expire = (r_state == S_WAIT) && (r_wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state != S_WAIT) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_err <= r_err;
    end else if ((r_state == S_ERR) && go) begin
      r_err <= 1'b0;
    end else if (w_expire && !solver_done) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_expire = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_step_req     <= 1'b0;
      r_step_idx     <= '0;
      r_solver_start <= 1'b0;
      r_beta_valid   <= 1'b0;
      r_beta_step    <= '0;
      r_beta_out     <= '0;
    end else begin
      // Pulse outputs fall back to 0 unless a transition below re-arms them.
      r_done         <= 1'b0;
      r_solver_start <= 1'b0;
      r_beta_valid   <= 1'b0;

      if (abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_step_req <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_ERR: begin
            if (go) begin
              r_state    <= S_REQ;
              r_step_idx <= LAST_IDX;
              r_busy     <= 1'b1;
              r_step_req <= 1'b1;
            end
          end
          S_REQ: begin
            if (mat_valid) begin
              r_state        <= S_START;
              r_step_req     <= 1'b0;
              r_solver_start <= 1'b1;
            end
          end
          S_START: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            // solver_done wins over a coincident watchdog expiry.
            if (solver_done) begin
              r_state      <= S_WRITE;
              r_beta_out   <= solver_beta;
              r_beta_step  <= r_step_idx;
              r_beta_valid <= 1'b1;
            end else if (w_expire) begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
            end
          end
          S_WRITE: begin
            if (r_step_idx == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_REQ;
              r_step_idx <= r_step_idx - 1'b1;
              r_step_req <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign step_req     = r_step_req;
  assign step_idx     = r_step_idx;
  assign solver_start = r_solver_start;
  assign beta_valid   = r_beta_valid;
  assign beta_step    = r_beta_step;
  assign beta_out     = r_beta_out;

endmodule

// File: tb/tb_regression_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regression_scheduler
// Self-checking bench for regression_scheduler with NUM_STEPS=4, TIMEOUT=8.
// Inputs change and outputs are sampled on the falling clock edge. Timeout
// scenarios are included when REGRESSION_SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_regression_scheduler;

  localparam int WIDTH     = 32;
  localparam int NUM_STEPS = 4;
  localparam int TIMEOUT   = 8;
  localparam int IDX_W     = 2;
  localparam int BW        = 3 * WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            go;
  logic            abort;
  logic            mat_valid;
  logic            solver_done;
  logic [BW-1:0]   solver_beta;
  logic            busy;
  logic            done;
  logic            err;
  logic            step_req;
  logic [IDX_W-1:0] step_idx;
  logic            solver_start;
  logic            beta_valid;
  logic [IDX_W-1:0] beta_step;
  logic [BW-1:0]   beta_out;

  int n_chk  = 0;
  int n_fail = 0;
  int n_bv   = 0;
  int n_done = 0;
  logic [BW-1:0] exp_beta;

  always #5 clk = ~clk;

  regression_scheduler #(
    .WIDTH     (WIDTH),
    .NUM_STEPS (NUM_STEPS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .step_req     (step_req),
    .step_idx     (step_idx),
    .mat_valid    (mat_valid),
    .solver_start (solver_start),
    .solver_done  (solver_done),
    .solver_beta  (solver_beta),
    .beta_valid   (beta_valid),
    .beta_step    (beta_step),
    .beta_out     (beta_out)
  );

  // Pulse scoreboard: counts each cycle a strobe was high.
  always @(posedge clk) begin
    if (beta_valid === 1'b1) n_bv++;
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [BW-1:0] rand_beta();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_reset(input string pfx);
    chk({pfx, ".busy"},         BW'(busy),         '0);
    chk({pfx, ".done"},         BW'(done),         '0);
    chk({pfx, ".err"},          BW'(err),          '0);
    chk({pfx, ".step_req"},     BW'(step_req),     '0);
    chk({pfx, ".solver_start"}, BW'(solver_start), '0);
    chk({pfx, ".beta_valid"},   BW'(beta_valid),   '0);
    chk({pfx, ".step_idx"},     BW'(step_idx),     '0);
    chk({pfx, ".beta_step"},    BW'(beta_step),    '0);
    chk({pfx, ".beta_out"},     beta_out,          '0);
  endtask

  // mode 0: random delays/latencies with go and solver_done noise in REQ
  // mode 1: mat_valid always 1, solver latency 5
  // mode 2: abort in WAIT at step 2 (together with solver_done), then late solver_done
  // mode 3: one-cycle reset in the first WAIT
  // mode 4: watchdog expiry at the first step, then restart and full run
  // mode 5: solver_done on the expiry cycle at the first step
  task automatic run(input int mode);
    int bv0, dn0, dly, lat, exp_bv, exp_dn;
    bit ended, to_done;
    logic [BW-1:0] b;
    bv0 = n_bv; dn0 = n_done;
    exp_bv = NUM_STEPS; exp_dn = 1;
    ended = 1'b0; to_done = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    mat_valid = (mode == 1);
    for (int s = NUM_STEPS - 1; s >= 0 && !ended; s--) begin
      chk("req.step_req", BW'(step_req), BW'(1));
      chk("req.step_idx", BW'(step_idx), BW'(s));
      chk("req.busy",     BW'(busy),     BW'(1));
      dly = (mode == 0) ? $urandom_range(1, 3) : 0;
      for (int d = 0; d < dly; d++) begin
        go = (d == 0);
        solver_done = (d == 1);
        solver_beta = rand_beta();
        tick();
        go = 1'b0; solver_done = 1'b0;
        chk("hold.step_idx",   BW'(step_idx),   BW'(s));
        chk("hold.step_req",   BW'(step_req),   BW'(1));
        chk("hold.beta_valid", BW'(beta_valid), '0);
        chk("hold.beta_out",   beta_out,        exp_beta);
      end
      mat_valid = 1'b1; tick(); mat_valid = (mode == 1);
      chk("start.pulse",    BW'(solver_start), BW'(1));
      chk("start.step_req", BW'(step_req),     '0);
      tick();
      chk("wait.start_low", BW'(solver_start), '0);
      if (mode == 2 && s == 2) begin
        abort = 1'b1; solver_done = 1'b1; solver_beta = rand_beta();
        tick();
        abort = 1'b0; solver_done = 1'b0;
        chk("abort.busy",       BW'(busy),       '0);
        chk("abort.beta_valid", BW'(beta_valid), '0);
        chk("abort.step_req",   BW'(step_req),   '0);
        chk("abort.done",       BW'(done),       '0);
        solver_done = 1'b1; solver_beta = rand_beta();
        tick();
        solver_done = 1'b0;
        chk("abort.late_bv",   BW'(beta_valid), '0);
        chk("abort.late_busy", BW'(busy),       '0);
        chk("abort.beta_hold", beta_out,        exp_beta);
        exp_bv = NUM_STEPS - 1 - s; exp_dn = 0; ended = 1'b1;
      end else if (mode == 3 && s == NUM_STEPS - 1) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        exp_beta = '0;
        chk_reset("midrst");
        exp_bv = 0; exp_dn = 0; ended = 1'b1;
      end else if (mode == 4 && !to_done) begin
        repeat (TIMEOUT - 1) tick();
        chk("to.err_pre",  BW'(err),  '0);
        chk("to.busy_pre", BW'(busy), BW'(1));
        tick();
        chk("to.err",      BW'(err),        BW'(1));
        chk("to.busy",     BW'(busy),       '0);
        chk("to.bv",       BW'(beta_valid), '0);
        repeat (2) tick();
        chk("to.err_sticky", BW'(err), BW'(1));
        go = 1'b1; tick(); go = 1'b0;
        chk("to.err_clr", BW'(err), '0);
        to_done = 1'b1;
        s = NUM_STEPS;
      end else begin
        lat = (mode == 1) ? 5 : ((mode == 5 && s == NUM_STEPS - 1) ? TIMEOUT : $urandom_range(1, 6));
        repeat (lat - 1) tick();
        b = rand_beta();
        solver_done = 1'b1; solver_beta = b;
        tick();
        solver_done = 1'b0;
        exp_beta = b;
        chk("write.beta_valid", BW'(beta_valid), BW'(1));
        chk("write.beta_step",  BW'(beta_step),  BW'(s));
        chk("write.beta_out",   beta_out,        b);
        chk("write.err",        BW'(err),        '0);
        chk("write.done",       BW'(done),       '0);
        tick();
        if (s == 0) begin
          chk("done.pulse", BW'(done),       BW'(1));
          chk("done.bv",    BW'(beta_valid), '0);
          tick();
          chk("idle.done", BW'(done), '0);
          chk("idle.busy", BW'(busy), '0);
        end
      end
    end
    mat_valid = 1'b0;
    tick(); tick();
    chk("cnt.beta_valid", BW'(n_bv - bv0),   BW'(exp_bv));
    chk("cnt.done",       BW'(n_done - dn0), BW'(exp_dn));
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; mat_valid = 1'b0;
    solver_done = 1'b0; solver_beta = '0;
    exp_beta = '0;
    repeat (2) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk("post_reset.busy", BW'(busy), '0);
    run(1);
    run(2);
    run(3);
`ifdef REGRESSION_SCHED_TIMEOUT_EN
    run(4);
    run(5);
`endif
    repeat (6) run(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regression_scheduler.md
REGRESSION_SCHEDULER -- requirements
Module: regression_scheduler

Interface
REQ-001 Parameter WIDTH, default 32: fixed-point word width of the beta coefficients.
REQ-002 Parameter NUM_STEPS, default 16: number of backward-induction time steps sequenced per run (>=1).
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles allowed per solve.
REQ-004 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst_n, input, 1: synchronous active-low reset.
REQ-007 Port go, input, 1: run request, sampled in IDLE or ERR only.
REQ-008 Port abort, input, 1: cancel the current run.
REQ-009 Port busy, output, 1: high from the cycle after an accepted go until DONE, ERR or abort.
REQ-010 Port done, output, 1: single-cycle run-complete pulse.
REQ-011 Port err, output, 1: sticky solver-timeout flag.
REQ-012 Port step_req, output, 1: requests normal-equation data for step_idx.
REQ-013 Port step_idx, output, $clog2(NUM_STEPS) (min 1): current time step.
REQ-014 Port mat_valid, input, 1: upstream A/B matrices for step_idx are stable.
REQ-015 Port solver_start, output, 1: single-cycle start pulse to the 3x3 solver.
REQ-016 Port solver_done, input, 1: solver completion.
REQ-017 Port solver_beta, input, 3*WIDTH: solver result, beta[0] in the LSBs.
REQ-018 Port beta_valid, output, 1: single-cycle output strobe.
REQ-019 Port beta_step, output, $clog2(NUM_STEPS): step index of beta_out.
REQ-020 Port beta_out, output, 3*WIDTH: latched coefficients.

Function
REQ-021 FSM states SHALL be IDLE, REQ, START, WAIT, WRITE, DONE, ERR.
REQ-022 IDLE: when go=1, load step_idx=NUM_STEPS-1, set busy, and move to REQ.
REQ-023 REQ: hold step_req=1; when mat_valid=1, move to START, with step_req low from the next cycle.
REQ-024 START: assert solver_start for exactly one cycle, then move to WAIT.
REQ-025 WAIT: on solver_done=1, latch solver_beta into beta_out and move to WRITE.
REQ-026 WRITE: assert beta_valid for one cycle with beta_step=step_idx. If step_idx==0, move to DONE; otherwise decrement step_idx and return to REQ.
REQ-027 DONE: pulse done for one cycle, clear busy, and return to IDLE.
REQ-028 Minimum latency per step is 4 cycles: mat_valid at REQ, START, WAIT with solver_done, WRITE.
REQ-029 go outside IDLE or ERR SHALL be ignored.
REQ-030 abort=1 in any non-IDLE state: next state is IDLE, busy=0, no done, no beta_valid. abort has priority over go and over solver_done.
REQ-031 ERR: err=1 and busy=0; go clears err and starts a new run as in IDLE.
REQ-032 beta_out SHALL hold its value between captures; solver_done outside WAIT SHALL be ignored.

Reset
REQ-033 While rst_n=0 at a clk edge: state=IDLE; busy, done, err, step_req, solver_start and beta_valid are 0; step_idx, beta_step and beta_out are 0.
REQ-034 Reset mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-035 Macro REGRESSION_SCHED_TIMEOUT_EN, when defined, enables the WAIT watchdog. The counter clears on WAIT entry and increments each WAIT cycle. On reaching TIMEOUT without solver_done, the next state is ERR. If solver_done and expiry coincide, solver_done wins.
REQ-036 Without the macro: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Structure
REQ-037 A shared package SHALL hold the state enum type and the default WIDTH constant, shared with the solver.
REQ-038 No sub-module; the watchdog counter is inline logic guarded by the macro.

Verification
REQ-039 NUM_STEPS=4, mat_valid always 1, solver_done 5 cycles after each solver_start -> beta_valid with beta_step 3,2,1,0 in order, each beta_out equal to the solver_beta driven, then done exactly 1 cycle after the last beta_valid.
REQ-040 Macro on, TIMEOUT=8, solver never completes -> err=1 and busy=0 after 8 WAIT cycles; a subsequent go clears err and restarts at step_idx=3.
REQ-041 abort asserted in WAIT at step 2 -> IDLE next cycle, no beta_valid, no done; a later solver_done is ignored.
REQ-042 go pulsed while busy in REQ -> no effect: step_idx unchanged and a single done at the end.
REQ-043 rst_n=0 for 1 cycle mid-WAIT -> all outputs return to their reset values next cycle, no done.
REQ-044 Macro on, solver_done arrives on the same cycle the watchdog count reaches TIMEOUT -> WRITE with beta_valid, err stays 0.
